// File: rtl/bcd2_down_pkg.sv
// Shared types, constants and helpers for the two-digit BCD down counter.
package bcd2_down_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [7:0] BCD_ZERO      = 8'h00;

  function automatic logic bcd_digit_valid(input logic [3:0] nibble);
    return (nibble <= BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd2_down_digit.sv
// One BCD digit counting down 9..0 with parallel load and a combinational borrow.
module bcd1_down
  import bcd2_down_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] digit_reg;

  // Load beats count; a decrement through zero wraps to 9 and borrows.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_reg <= 4'd0;
    end else if (ld) begin
      digit_reg <= ld_val;
    end else if (en) begin
      digit_reg <= (digit_reg == 4'd0) ? BCD_DIGIT_MAX : digit_reg - 4'd1;
    end
  end

  assign digit      = digit_reg;
  assign borrow_out = en & (digit_reg == 4'd0);

endmodule

// File: rtl/bcd2_down.sv
// Two-digit BCD down counter with validated load, run/done FSM and terminal pulse.
// Optional periodic reload on terminal count when BCD2_DOWN_RELOAD_EN is defined.
module bcd2_down
  import bcd2_down_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       x,
  output logic [7:0] bcd2_out,
  output logic       zero,
  output logic       busy,
  output logic       done,
  output logic       load_err
);

  state_t     state_reg, state_next;
  logic       done_reg, load_err_reg;
  logic       load_valid, load_ok, dec, terminal;
  logic       digit_ld;
  logic [7:0] digit_ld_val;
  logic       ones_borrow, tens_borrow;
  logic [3:0] ones_digit, tens_digit;

  assign load_valid = bcd_digit_valid(load_val[7:4]) & bcd_digit_valid(load_val[3:0]);
  assign load_ok    = load & load_valid;
  // Any load, even a rejected one, masks x on that edge.
  assign dec        = x & ~load & (state_reg == RUN);
  assign terminal   = dec & (bcd2_out == 8'h01);

`ifdef BCD2_DOWN_RELOAD_EN
  logic [7:0] reload_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      reload_reg <= BCD_ZERO;
    end else if (load_ok && (load_val != BCD_ZERO)) begin
      reload_reg <= load_val;
    end
  end

  assign digit_ld     = load_ok | terminal;
  assign digit_ld_val = load_ok ? load_val : reload_reg;
`else
  assign digit_ld     = load_ok;
  assign digit_ld_val = load_val;
`endif

  bcd1_down u_ones (
    .clk        (clk),
    .reset      (reset),
    .en         (dec),
    .ld         (digit_ld),
    .ld_val     (digit_ld_val[3:0]),
    .digit      (ones_digit),
    .borrow_out (ones_borrow)
  );

  bcd1_down u_tens (
    .clk        (clk),
    .reset      (reset),
    .en         (ones_borrow),
    .ld         (digit_ld),
    .ld_val     (digit_ld_val[7:4]),
    .digit      (tens_digit),
    .borrow_out (tens_borrow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      done_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      done_reg     <= terminal;
      load_err_reg <= load & ~load_valid;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (load_ok) begin
      state_next = (load_val != BCD_ZERO) ? RUN : IDLE;
    end else if (terminal) begin
`ifdef BCD2_DOWN_RELOAD_EN
      state_next = RUN;
`else
      state_next = DONE;
`endif
    end else if (tens_borrow) begin
      // Underflow from 00 only follows a corrupted state; park rather than keep counting.
      state_next = IDLE;
    end
  end

  assign bcd2_out = {tens_digit, ones_digit};
  assign zero     = (bcd2_out == BCD_ZERO);
  assign busy     = (state_reg == RUN);
  assign done     = done_reg;
  assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd2_down.sv
// Scoreboard bench for bcd2_down: stimulus pushes expected outputs, a monitor pops and checks.
module tb_bcd2_down;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       x = 1'b0;
  logic [7:0] bcd2_out;
  logic       zero, busy, done, load_err;

  typedef struct {
    string      name;
    logic [7:0] out;
    logic       zero;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bcd2_down dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .x        (x),
    .bcd2_out (bcd2_out),
    .zero     (zero),
    .busy     (busy),
    .done     (done),
    .load_err (load_err)
  );

  // One edge of stimulus plus the outputs expected just after that edge.
  task automatic step(input string nm, input logic r, input logic ld, input logic [7:0] lv,
                      input logic xi, input logic [7:0] eo, input logic ez, input logic eb,
                      input logic ed, input logic ee);
    exp_t e;
    @(negedge clk);
    reset = r; load = ld; load_val = lv; x = xi;
    e.name = nm; e.out = eo; e.zero = ez; e.busy = eb; e.done = ed; e.err = ee;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: every edge with a pending expectation is one transaction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({bcd2_out, zero, busy, done, load_err} !== {e.out, e.zero, e.busy, e.done, e.err}) begin
          n_bad++;
          $display("FAIL %s: got out=%h zero=%b busy=%b done=%b err=%b, want out=%h zero=%b busy=%b done=%b err=%b",
                   e.name, bcd2_out, zero, busy, done, load_err, e.out, e.zero, e.busy, e.done, e.err);
        end else begin
          $display("ok   %s: out=%h zero=%b busy=%b done=%b err=%b",
                   e.name, bcd2_out, zero, busy, done, load_err);
        end
      end
    end
  end

  initial begin
    // Reset held two edges with x high.
    step("reset0", 1, 0, 8'h00, 1, 8'h00, 1, 0, 0, 0);
    step("reset1", 1, 0, 8'h00, 1, 8'h00, 1, 0, 0, 0);
    step("idle_x", 0, 0, 8'h00, 1, 8'h00, 1, 0, 0, 0);

    // Load and count through a borrow.
    step("load21", 0, 1, 8'h21, 0, 8'h21, 0, 1, 0, 0);
    step("dec20",  0, 0, 8'h00, 1, 8'h20, 0, 1, 0, 0);
    step("dec19",  0, 0, 8'h00, 1, 8'h19, 0, 1, 0, 0);
    step("dec18",  0, 0, 8'h00, 1, 8'h18, 0, 1, 0, 0);
    step("hold18", 0, 0, 8'h00, 0, 8'h18, 0, 1, 0, 0);

    // Terminal count.
    step("load02", 0, 1, 8'h02, 0, 8'h02, 0, 1, 0, 0);
    step("dec01",  0, 0, 8'h00, 1, 8'h01, 0, 1, 0, 0);
`ifdef BCD2_DOWN_RELOAD_EN
    step("term",   0, 0, 8'h00, 1, 8'h02, 0, 1, 1, 0);
    step("post1",  0, 0, 8'h00, 1, 8'h01, 0, 1, 0, 0);
    step("post2",  0, 0, 8'h00, 1, 8'h02, 0, 1, 1, 0);
`else
    step("term",   0, 0, 8'h00, 1, 8'h00, 1, 0, 1, 0);
    step("post1",  0, 0, 8'h00, 1, 8'h00, 1, 0, 0, 0);
    step("post2",  0, 0, 8'h00, 1, 8'h00, 1, 0, 0, 0);
`endif

    // Invalid loads leave count and state alone; x on the same edge is ignored.
    step("load45", 0, 1, 8'h45, 0, 8'h45, 0, 1, 0, 0);
    step("bad3A",  0, 1, 8'h3A, 1, 8'h45, 0, 1, 0, 1);
    step("gap",    0, 0, 8'h00, 0, 8'h45, 0, 1, 0, 0);
    step("badA3",  0, 1, 8'hA3, 1, 8'h45, 0, 1, 0, 1);
    step("gap2",   0, 0, 8'h00, 0, 8'h45, 0, 1, 0, 0);

    // Reset mid-run wins over load and x.
    step("load99", 0, 1, 8'h99, 0, 8'h99, 0, 1, 0, 0);
    step("dec98",  0, 0, 8'h00, 1, 8'h98, 0, 1, 0, 0);
    step("dec97",  0, 0, 8'h00, 1, 8'h97, 0, 1, 0, 0);
    step("dec96",  0, 0, 8'h00, 1, 8'h96, 0, 1, 0, 0);
    step("dec95",  0, 0, 8'h00, 1, 8'h95, 0, 1, 0, 0);
    step("dec94",  0, 0, 8'h00, 1, 8'h94, 0, 1, 0, 0);
    step("rst_run",1, 1, 8'h99, 1, 8'h00, 1, 0, 0, 0);
    step("after_r",0, 0, 8'h00, 1, 8'h00, 1, 0, 0, 0);

    // Loading 00 goes to IDLE.
    step("load00", 0, 1, 8'h00, 1, 8'h00, 1, 0, 0, 0);
    step("idle00", 0, 0, 8'h00, 1, 8'h00, 1, 0, 0, 0);

    // Continuous x from 10: terminal on the 10th edge.
    step("load10", 0, 1, 8'h10, 0, 8'h10, 0, 1, 0, 0);
    step("c09",    0, 0, 8'h00, 1, 8'h09, 0, 1, 0, 0);
    step("c08",    0, 0, 8'h00, 1, 8'h08, 0, 1, 0, 0);
    step("c07",    0, 0, 8'h00, 1, 8'h07, 0, 1, 0, 0);
    step("c06",    0, 0, 8'h00, 1, 8'h06, 0, 1, 0, 0);
    step("c05",    0, 0, 8'h00, 1, 8'h05, 0, 1, 0, 0);
    step("c04",    0, 0, 8'h00, 1, 8'h04, 0, 1, 0, 0);
    step("c03",    0, 0, 8'h00, 1, 8'h03, 0, 1, 0, 0);
    step("c02",    0, 0, 8'h00, 1, 8'h02, 0, 1, 0, 0);
    step("c01",    0, 0, 8'h00, 1, 8'h01, 0, 1, 0, 0);
`ifdef BCD2_DOWN_RELOAD_EN
    step("c_term", 0, 0, 8'h00, 1, 8'h10, 0, 1, 1, 0);
`else
    step("c_term", 0, 0, 8'h00, 1, 8'h00, 1, 0, 1, 0);
`endif

    // Load and x together at 01: load wins, no done.
    step("load02b",0, 1, 8'h02, 0, 8'h02, 0, 1, 0, 0);
    step("dec01b", 0, 0, 8'h00, 1, 8'h01, 0, 1, 0, 0);
    step("ld_term",0, 1, 8'h05, 1, 8'h05, 0, 1, 0, 0);
    step("dec04",  0, 0, 8'h00, 1, 8'h04, 0, 1, 0, 0);
    step("bad9F",  0, 1, 8'h9F, 1, 8'h04, 0, 1, 0, 1);

`ifdef BCD2_DOWN_RELOAD_EN
    // Periodic reload from 03.
    step("r_ld03", 0, 1, 8'h03, 0, 8'h03, 0, 1, 0, 0);
    step("r02a",   0, 0, 8'h00, 1, 8'h02, 0, 1, 0, 0);
    step("r01a",   0, 0, 8'h00, 1, 8'h01, 0, 1, 0, 0);
    step("r03a",   0, 0, 8'h00, 1, 8'h03, 0, 1, 1, 0);
    step("r02b",   0, 0, 8'h00, 1, 8'h02, 0, 1, 0, 0);
    step("r01b",   0, 0, 8'h00, 1, 8'h01, 0, 1, 0, 0);
    step("r03b",   0, 0, 8'h00, 1, 8'h03, 0, 1, 1, 0);
`endif

    @(negedge clk);
    x = 1'b0; load = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd2_down.md
# bcd2_down

Two-digit BCD down counter with parallel load, terminal-count detection and a small run/done state machine. It is the countdown counterpart of the team's two-digit BCD up counter. It shares that block's packed output format {tens, ones} and its per-edge count strobe `x`. It sits between the front-panel load logic and the 7-segment display path, and drives countdown and timer functions.

## Interface
Parameters:
- none (the width is fixed at two BCD digits).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  parallel-load request, sampled at the rising edge.
- load_val  in  8  value to load, {tens[7:4], ones[3:0]} in BCD.
- x  in  1  count-down strobe; one decrement per rising edge at which it is high.
- bcd2_out  out  8  current count, {tens, ones}, registered.
- zero  out  1  high when bcd2_out == 8'h00 (decoded from the register).
- busy  out  1  high while in state RUN.
- done  out  1  one-cycle pulse when the count reaches terminal.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- Reset values: bcd2_out=8'h00, zero=1, busy=0, done=0, load_err=0, state=IDLE. A reset also clears the reload register (under the macro). Reset overrides load and x, including mid-run.
- States:
  - IDLE: x is ignored.
  - RUN: x decrements the count.
  - DONE: the count is held at 00 and x is ignored.
- Priority on each edge: reset > load > x.
- Load with a valid value (both nibbles ≤ 9):
  - bcd2_out <= load_val.
  - The next state is RUN if load_val != 00, otherwise IDLE.
  - A load is accepted from any state.
- Load with an invalid value (either nibble ≥ 4'hA):
  - bcd2_out and state are unchanged.
  - load_err pulses for one cycle.
  - x on the same edge is ignored.
- Decrement in RUN (x=1, load=0):
  - ones == 0 → ones becomes 9 and a borrow goes to tens. Otherwise ones decrements by 1.
  - tens decrements only on a borrow.
  - Arithmetic is per nibble. Values outside 0–9 can never be stored.
- Terminal count: a decrement from 8'h01 gives 8'h00. On that edge done pulses high for one cycle and the state moves to DONE.
- 8'h00 in RUN cannot occur, because a load of 00 goes to IDLE.
- Simultaneous load and x at terminal: load wins and done does not pulse.

## Timing
- All outputs are registered or decoded from registers. There is no combinational path from input to output.
- Latency: one cycle. Effects of the inputs sampled at edge N are visible after edge N.
- done is asserted in the same cycle that bcd2_out first shows 00.
- load_err is asserted in the cycle after the rejected load edge.
- Continuous x=1 from load 8'h10 reaches 00 after exactly 10 edges.

## Configuration
- Macro: BCD2_DOWN_RELOAD_EN.
- With the macro defined:
  - A valid nonzero load also writes an 8-bit reload register.
  - The decrement from 01 writes the reload value instead of 00.
  - done pulses and the state stays RUN, so the counter runs as a periodic timer.
  - DONE is unreachable.
  - zero stays 0 during a run.
- Without the macro: there is no reload register and terminal behaviour is as described in Operation.

## Structure
- Package bcd2_down_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - localparam BCD_DIGIT_MAX = 4'd9;
  - localparam BCD_ZERO = 8'h00;
  - a function bcd_digit_valid(nibble).
- Sub-module bcd1_down, instantiated twice and chained through its borrow output:
  - Ports: clk, reset, en, ld, ld_val[3:0], digit[3:0], borrow_out.
  - borrow_out = en & (digit == 0).
  - Borrow is combinational; each digit is a registered update.
- The top level contains only the load validation, the FSM, done and load_err generation, and the reload register.

## Test plan
- Reset then idle: assert reset 2 cycles with x=1 → bcd2_out=00, zero=1, busy=0; x is ignored in IDLE.
- Load and count through a borrow: load 8'h21, then x=1 for 3 edges → 20, 19, 18; busy=1.
- Terminal: load 8'h02, x=1 for 3 edges → 01, 00 with done=1 for exactly one cycle, then held at 00 in DONE; further x has no effect.
- Invalid load: from 8'h45, load 8'h3A → bcd2_out stays 45 and load_err pulses once; then load 8'hA3 → same result.
- Reset mid-run: load 8'h99, run 5 edges (count reaches 94), assert reset with load=1 → bcd2_out=00, state IDLE, no done pulse.
- With BCD2_DOWN_RELOAD_EN: load 8'h03, x continuous → 02, 01, 03, 02, 01, 03…; done pulses on each 01→03 edge; busy stays 1.
